// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_pkg
// Description : Shared definitions for the control_unit sequencer: opcode
//               constants, sequencer state enumeration and the bit positions
//               of the instruction fields inside the 12-bit instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package control_unit_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Opcodes (ir[11:9]); anything not listed executes as a NOP
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // Instruction field positions (low bit of each field)
    localparam int unsigned IR_W  = 12;
    localparam int unsigned OP_LO = 9;  // opcode       ir[11:9]
    localparam int unsigned RD_LO = 6;  // ALU dest     ir[8:6]
    localparam int unsigned RS_LO = 3;  // ALU src A    ir[5:3]
    localparam int unsigned RT_LO = 0;  // ALU src B    ir[2:0]
    localparam int unsigned MR_LO = 4;  // mem reg      ir[6:4]
    localparam int unsigned MA_LO = 0;  // mem address  ir[3:0]

    // Opcodes that need the EXEC state (and possibly WB)
    function automatic logic is_exec_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_ADD)  || (op == OP_SUB);
    endfunction

    // Opcodes that go through the ALU
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : control_unit_pkg
`default_nettype wire

// File: rtl/control_unit_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Program counter. Clears on reset, increments when inc is
//               high and wraps naturally from 2^PC_W-1 to 0.
// Ports       : clk, reset (async, active-high), inc (increment enable),
//               pc (current instruction memory address)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign pc = r_pc;

endmodule : pc_counter
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Fetch/decode/execute sequencer for the 12-bit processor.
//               Program mode runs from instruction memory until HALT; manual
//               mode executes one switch-entered instruction then idles.
// Ports       : clk, reset (async, active-high)
//               run/manual      - start request and run-mode select
//               ir              - instruction register contents
//               ir_ld/ir_sel    - instruction register load / source select
//               pc              - instruction memory address
//               rf_*            - register file addresses, write enable/select
//               alu_op          - 0 add, 1 subtract
//               dm_addr/dm_we   - data memory address / write enable
//               busy/done       - not-idle flag / end-of-sequence pulse
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import control_unit_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int DM_AW = 4,
    parameter int RF_AW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             manual,
    input  logic [11:0]      ir,
    output logic             ir_ld,
    output logic             ir_sel,
    output logic [PC_W-1:0]  pc,
    output logic [RF_AW-1:0] rf_ra,
    output logic [RF_AW-1:0] rf_rb,
    output logic [RF_AW-1:0] rf_wa,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             alu_op,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic             r_mode;
    logic [2:0]       r_op;
    logic [RF_AW-1:0] r_ra;
    logic [RF_AW-1:0] r_rb;
    logic [RF_AW-1:0] r_wa;
    logic             r_wsel;
    logic             r_alu_op;
    logic [DM_AW-1:0] r_dm_addr;
    logic             w_done;
    logic             w_pc_inc;
    logic [2:0]       w_op;

    assign w_op = ir[OP_LO +: 3];

    // State, run mode and captured instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_op      <= '0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_wa      <= '0;
            r_wsel    <= 1'b0;
            r_alu_op  <= 1'b0;
            r_dm_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && run) begin
                r_mode <= manual;
            end
            // Fields are captured only while leaving DECODE so the datapath
            // controls stay put through EXEC and WB and between sequences.
            if (r_state == S_DECODE) begin
                r_op      <= w_op;
                r_ra      <= is_alu_op(w_op) ? ir[RS_LO +: RF_AW] : ir[MR_LO +: RF_AW];
                r_rb      <= ir[RT_LO +: RF_AW];
                r_wa      <= is_alu_op(w_op) ? ir[RD_LO +: RF_AW] : ir[MR_LO +: RF_AW];
                r_wsel    <= is_alu_op(w_op);
                r_alu_op  <= (w_op == OP_SUB);
                r_dm_addr <= ir[MA_LO +: DM_AW];
            end
        end
    end

    // Next-state and end-of-sequence decode
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_exec_op(w_op)) begin
                    w_next = S_EXEC;
                end else begin
                    w_done = 1'b1;
                    w_next = (w_op == OP_HALT || r_mode) ? S_IDLE : S_FETCH;
                end
            end
            S_EXEC: begin
                if (r_op == OP_STORE) begin
                    w_done = 1'b1;
                    w_next = r_mode ? S_IDLE : S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_done = 1'b1;
                w_next = r_mode ? S_IDLE : S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // pc only advances for program-mode fetches
    assign w_pc_inc = (r_state == S_FETCH) && !r_mode;

    pc_counter #(
        .PC_W (PC_W)
    ) u_pc_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pc_inc),
        .pc    (pc)
    );

    assign ir_ld   = (r_state == S_FETCH);
    assign ir_sel  = r_mode;
    assign rf_we   = (r_state == S_WB);
    assign dm_we   = (r_state == S_EXEC) && (r_op == OP_STORE);
    assign busy    = (r_state != S_IDLE);
    assign done    = w_done;
    assign rf_ra   = r_ra;
    assign rf_rb   = r_rb;
    assign rf_wa   = r_wa;
    assign rf_wsel = r_wsel;
    assign alu_op  = r_alu_op;
    assign dm_addr = r_dm_addr;

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. The bench plays the
//               instruction register and instruction memory, and predicts
//               every control output per instruction from the instruction
//               format and the per-opcode cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        manual;
    logic [11:0] ir;
    logic        ir_ld, ir_sel, rf_we, rf_wsel, alu_op, dm_we, busy, done;
    logic [3:0]  pc, dm_addr;
    logic [2:0]  rf_ra, rf_rb, rf_wa;

    int checks = 0;
    int errors = 0;

    // Bench-side reference state
    logic [3:0]  m_pc   = 4'd0;
    logic        m_mode = 1'b0;
    logic [11:0] imem [16];

    control_unit dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .manual  (manual),
        .ir      (ir),
        .ir_ld   (ir_ld),
        .ir_sel  (ir_sel),
        .pc      (pc),
        .rf_ra   (rf_ra),
        .rf_rb   (rf_rb),
        .rf_wa   (rf_wa),
        .rf_we   (rf_we),
        .rf_wsel (rf_wsel),
        .alu_op  (alu_op),
        .dm_addr (dm_addr),
        .dm_we   (dm_we),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; optionally throw random run/manual noise at the busy DUT
    task automatic step(input bit noise);
        if (noise) begin
            run    = 1'($urandom % 2);
            manual = 1'($urandom % 2);
        end
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic start(input logic m);
        run    = 1'b1;
        manual = m;
        m_mode = m;
        step(1'b0);
    endtask

    // Executes one instruction; entered with the DUT in FETCH.
    // cont=1 means the DUT is expected back in FETCH afterwards.
    task automatic exec(input logic [11:0] instr, input bit noise, output bit cont);
        logic [2:0] op;
        logic       alu, ldst;
        logic [2:0] e_ra;
        op   = instr[11:9];
        alu  = (op == 3'd2) || (op == 3'd3);
        ldst = (op == 3'd0) || (op == 3'd1);
        e_ra = alu ? instr[5:3] : instr[6:4];

        chk("fetch_ir_ld",  {15'd0, ir_ld},  16'd1);
        chk("fetch_ir_sel", {15'd0, ir_sel}, {15'd0, m_mode});
        chk("fetch_busy",   {15'd0, busy},   16'd1);
        chk("fetch_done",   {15'd0, done},   16'd0);
        chk("fetch_pc",     {12'd0, pc},     {12'd0, m_pc});
        ir = instr;
        step(noise);
        if (!m_mode) m_pc = m_pc + 4'd1;

        chk("dec_pc",    {12'd0, pc},    {12'd0, m_pc});
        chk("dec_ir_ld", {15'd0, ir_ld}, 16'd0);
        chk("dec_we",    {14'd0, rf_we, dm_we}, 16'd0);
        chk("dec_done",  {15'd0, done},  {15'd0, !(alu || ldst)});
        if (alu || ldst) begin
            step(noise);
            chk("exec_dm_we", {15'd0, dm_we}, {15'd0, op == 3'd1});
            chk("exec_rf_we", {15'd0, rf_we}, 16'd0);
            chk("exec_done",  {15'd0, done},  {15'd0, op == 3'd1});
            if (op != 3'd0) chk("exec_rf_ra", {13'd0, rf_ra}, {13'd0, e_ra});
            if (alu) begin
                chk("exec_rf_rb",  {13'd0, rf_rb},  {13'd0, instr[2:0]});
                chk("exec_alu_op", {15'd0, alu_op}, {15'd0, op == 3'd3});
            end
            if (ldst) chk("exec_dm_addr", {12'd0, dm_addr}, {12'd0, instr[3:0]});
            if (op != 3'd1) begin
                step(noise);
                chk("wb_rf_we",   {15'd0, rf_we},   16'd1);
                chk("wb_dm_we",   {15'd0, dm_we},   16'd0);
                chk("wb_done",    {15'd0, done},    16'd1);
                chk("wb_rf_wa",   {13'd0, rf_wa},   {13'd0, alu ? instr[8:6] : instr[6:4]});
                chk("wb_rf_wsel", {15'd0, rf_wsel}, {15'd0, alu});
                if (alu) begin
                    chk("wb_rf_ra",  {13'd0, rf_ra},  {13'd0, e_ra});
                    chk("wb_rf_rb",  {13'd0, rf_rb},  {13'd0, instr[2:0]});
                    chk("wb_alu_op", {15'd0, alu_op}, {15'd0, op == 3'd3});
                end else begin
                    chk("wb_dm_addr", {12'd0, dm_addr}, {12'd0, instr[3:0]});
                end
            end
        end
        step(noise);
        cont = !m_mode && (op != 3'd7);
        if (!cont) begin
            chk("end_busy",  {15'd0, busy},  16'd0);
            chk("end_done",  {15'd0, done},  16'd0);
            chk("end_ir_ld", {15'd0, ir_ld}, 16'd0);
            chk("end_pc",    {12'd0, pc},    {12'd0, m_pc});
        end
    endtask

    task automatic run_manual(input logic [11:0] instr, input bit noise);
        bit cont;
        start(1'b1);
        exec(instr, noise, cont);
    endtask

    task automatic run_prog(input bit noise);
        bit cont;
        bit halted;
        halted = 1'b0;
        start(1'b0);
        for (int k = 0; k < 40; k++) begin
            exec(imem[m_pc], noise, cont);
            if (!cont) begin
                halted = 1'b1;
                break;
            end
        end
        chk("prog_halted", {15'd0, halted}, 16'd1);
    endtask

    initial begin
        logic [11:0] r_instr;
        logic [2:0]  r_op;
        reset  = 1'b1;
        run    = 1'b0;
        manual = 1'b0;
        ir     = 12'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: every output low
        chk("rst_outputs", {ir_ld, ir_sel, rf_we, rf_wsel, alu_op, dm_we, busy, done}, 16'd0);
        chk("rst_pc",      {12'd0, pc}, 16'd0);
        chk("rst_addrs",   {3'd0, rf_ra, rf_rb, rf_wa, dm_addr}, 16'd0);
        reset = 1'b0;
        step(1'b0);
        chk("idle_busy", {15'd0, busy}, 16'd0);

        // Directed: manual ADD and SUB
        run_manual(12'h40A, 1'b0);
        run_manual(12'h6D1, 1'b0);

        // Directed program: LOAD, STORE, HALT -> pc ends at 3
        for (int i = 0; i < 16; i++) imem[i] = 12'h800;
        imem[0] = 12'h015;
        imem[1] = 12'h213;
        imem[2] = 12'hE00;
        run_prog(1'b0);
        chk("prog_pc3", {12'd0, pc}, 16'd3);

        // NOPs from pc 3 through the wrap to a HALT at address 1
        for (int i = 0; i < 16; i++) imem[i] = 12'h800;
        imem[1] = 12'hE00;
        run_prog(1'b1);
        chk("wrap_pc", {12'd0, pc}, 16'd2);

        // Asynchronous reset during WB of an ADD
        start(1'b1);
        ir = 12'h40A;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("pre_rst_rf_we", {15'd0, rf_we}, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rf_we", {15'd0, rf_we}, 16'd0);
        chk("midrst_busy",  {15'd0, busy},  16'd0);
        chk("midrst_pc",    {12'd0, pc},    16'd0);
        chk("midrst_done",  {15'd0, done},  16'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_pc   = 4'd0;
        m_mode = 1'b0;
        step(1'b0);
        chk("postrst_busy", {15'd0, busy}, 16'd0);

        // Random manual instructions with run/manual noise while busy
        for (int n = 0; n < 25; n++) begin
            r_instr = 12'($urandom);
            run_manual(r_instr, 1'b1);
        end

        // Random programs ending at one HALT
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                r_instr = 12'($urandom);
                r_op    = r_instr[11:9];
                if (r_op == 3'd7) r_instr[11:9] = 3'd4;
                imem[i] = r_instr;
            end
            imem[4'($urandom)] = 12'hE00;
            run_prog(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_control_unit
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the simple 12-bit processor. Sits directly downstream of the instruction register and consumes its 12-bit output.
- Drives the instruction register's load and source-select, the program counter / instruction-memory address, and the register-file, ALU and data-memory controls.
- Two run modes:
  - Program mode: runs from instruction memory until HALT.
  - Manual mode: executes one switch-entered instruction, then returns to idle.

Parameters:
- PC_W, 4, program counter / instruction memory address width (2^PC_W words)
- DM_AW, 4, data memory address width
- RF_AW, 3, register file address width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- run  in  1  start request (debounced, single-cycle pulse); ignored unless IDLE
- manual  in  1  sampled on accepted run: 1 = manual (switch instruction), 0 = program mode
- ir  in  12  instruction register contents
- ir_ld  out  1  instruction register load enable
- ir_sel  out  1  instruction register source: 1 = switch input, 0 = instruction memory
- pc  out  PC_W  instruction memory address
- rf_ra  out  RF_AW  register file read port A address
- rf_rb  out  RF_AW  register file read port B address
- rf_wa  out  RF_AW  register file write address
- rf_we  out  1  register file write enable
- rf_wsel  out  1  write data: 0 = data memory read data, 1 = ALU result
- alu_op  out  1  0 = add, 1 = subtract
- dm_addr  out  DM_AW  data memory address
- dm_we  out  1  data memory write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an execution sequence ends

Behaviour:
- Instruction format: opcode = ir[11:9].
  - 000 LOAD: RF[ir[6:4]] <= DM[ir[3:0]]
  - 001 STORE: DM[ir[3:0]] <= RF[ir[6:4]]
  - 010 ADD: RF[ir[8:6]] <= RF[ir[5:3]] + RF[ir[2:0]]
  - 011 SUB: same fields as ADD, subtract
  - 111 HALT
  - all other opcodes: NOP
- States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE:
  - On run=1, latch manual into mode_q and go to FETCH.
  - run=0: stay in IDLE.
- FETCH:
  - ir_ld=1, ir_sel=mode_q.
  - In program mode, pc increments at the end of FETCH. Wrap from 2^PC_W-1 to 0.
  - Next state: DECODE.
- DECODE:
  - ir is valid in this state; register opcode and fields into internal copies.
  - HALT or NOP: done=1 for one cycle. Next state is IDLE if HALT or mode_q=1; otherwise FETCH (NOP only).
  - Otherwise: EXEC.
- EXEC:
  - Drive rf_ra, rf_rb, alu_op and dm_addr from the captured fields.
  - STORE: dm_we=1 for exactly this cycle; rf_ra = ir[6:4]. Then end the sequence: done=1; go to IDLE if mode_q=1, else FETCH.
  - LOAD/ADD/SUB: next state WB.
- WB:
  - rf_we=1 for one cycle.
  - rf_wa: ir[6:4] for LOAD, ir[8:6] for ADD/SUB.
  - rf_wsel: 0 for LOAD, 1 for ADD/SUB.
  - Read addresses and dm_addr stay held from EXEC.
  - Then end the sequence: done=1; go to IDLE if mode_q=1, else FETCH.
- Latency from FETCH to completion: LOAD/ADD/SUB 4 cycles, STORE 3, HALT/NOP 2.
- Output timing:
  - ir_ld, rf_we and dm_we are Moore outputs of the state.
  - Address and operation outputs come from registered fields; they stay stable outside their active states.
- Reset (any state, any cycle):
  - State = IDLE, pc = 0, mode_q = 0, captured fields = 0.
  - All outputs 0.
  - Any in-flight write enable drops immediately.
- Manual mode never changes pc.
- run asserted while busy=1 is ignored and not queued.
- The manual input is only sampled when run is accepted; changes mid-sequence have no effect.
- Arithmetic is performed in the datapath; this block only selects the operation. No carry or overflow handling.

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_HALT), state enum, and instruction field bit positions.
- One natural sub-module: pc_counter (load-to-zero on reset, increment enable, wrap).

Test Plan:
- Reset mid-WB of an ADD -> same cycle: rf_we=0, busy=0, pc=0; IDLE afterwards.
- Manual mode, ir=0x40A (ADD RF[0] <= RF[1]+RF[2]):
  - run pulse -> FETCH with ir_ld=1, ir_sel=1.
  - WB on the 4th cycle with rf_wa=0, rf_wsel=1, alu_op=0.
  - done, then IDLE; pc unchanged.
- Program mode, LOAD 0x015 then STORE 0x213 then HALT 0xE00 at addresses 0..2:
  - dm_addr=5 and rf_we in WB (rf_wa=1) for the LOAD.
  - dm_we=1 with dm_addr=3, rf_ra=1 for the STORE.
  - Stops with pc=3, done pulse, busy=0.
- run pulses during busy -> ignored; exactly one done per accepted run.
- pc=15 with program mode NOPs (opcode 100) -> pc wraps to 0 and fetching continues.
- SUB 0x6D1 -> alu_op=1, rf_ra=2, rf_rb=1, rf_wa=3.
